counter_sequence_ctrl: RTL and testbench

Programmable interval controller that owns and sequences a 4-bit unsigned up-counter datapath. A prescaler gates the counter's count enable, and a small FSM handles start, stop, pause and terminal-count detection. It supports one-shot and periodic modes and raises a single-cycle DONE per completed interval. It is the control layer used wherever a counter must run for a host-specified number of prescaled ticks.

---
 rtl/counter_sequence_ctrl.sv | 151 +++++++++++++++
 tb/tb_counter_sequence_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequence_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequence_ctrl
// Brief    : Prescaled 4-bit interval counter with start/stop/pause control,
//            one-shot or periodic operation and a one-cycle DONE per interval.
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequence_ctrl #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 8
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             START,
    input  logic             STOP,
    input  logic             PAUSE,
    input  logic             MODE,
    input  logic [WIDTH-1:0] TC,
    input  logic [PRE_W-1:0] PRESCALE,
    output logic [WIDTH-1:0] Q,
    output logic             TICK,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_q_zero = '0;
    localparam logic [WIDTH-1:0] c_q_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] c_p_zero = '0;
    localparam logic [PRE_W-1:0] c_p_one  = {{(PRE_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic [PRE_W-1:0]   r_pcnt;
    logic [WIDTH-1:0]   r_tc_l;
    logic [PRE_W-1:0]   r_pre_l;
    logic               r_mode_l;
    logic               r_tick;
    logic               r_done;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [PRE_W-1:0]   w_pcnt_nxt;
    logic [WIDTH-1:0]   w_tc_nxt;
    logic [PRE_W-1:0]   w_pre_nxt;
    logic               w_mode_nxt;
    logic               w_tick_nxt;
    logic               w_done_nxt;
    logic               w_tick_evt;
    logic               w_terminal;

    assign w_tick_evt = (r_pcnt == r_pre_l);
    assign w_terminal = (r_q == r_tc_l);

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_state  <= S_IDLE;
            r_q      <= c_q_zero;
            r_pcnt   <= c_p_zero;
            r_tc_l   <= c_q_zero;
            r_pre_l  <= c_p_zero;
            r_mode_l <= 1'b0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_tc_l   <= w_tc_nxt;
            r_pre_l  <= w_pre_nxt;
            r_mode_l <= w_mode_nxt;
            r_tick   <= w_tick_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_pcnt_nxt  = r_pcnt;
        w_tc_nxt    = r_tc_l;
        w_pre_nxt   = r_pre_l;
        w_mode_nxt  = r_mode_l;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (START && !STOP) begin
                    w_state_nxt = S_RUN;
                    w_q_nxt     = c_q_zero;
                    w_pcnt_nxt  = c_p_zero;
                    w_tc_nxt    = TC;
                    w_pre_nxt   = PRESCALE;
                    w_mode_nxt  = MODE;
                end
            end

            // HOLD with PAUSE low counts in the same cycle it resumes, so a
            // pause of N cycles stretches the interval by exactly N.
            S_RUN, S_HOLD: begin
                if (STOP) begin
                    w_state_nxt = S_IDLE;
                end else if (START) begin
                    w_state_nxt = S_RUN;
                    w_q_nxt     = c_q_zero;
                    w_pcnt_nxt  = c_p_zero;
                    w_tc_nxt    = TC;
                    w_pre_nxt   = PRESCALE;
                    w_mode_nxt  = MODE;
                end else if (PAUSE) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_RUN;
                    if (!w_tick_evt) begin
                        w_pcnt_nxt = r_pcnt + c_p_one;
                    end else begin
                        w_pcnt_nxt = c_p_zero;
                        w_tick_nxt = 1'b1;
                        if (!w_terminal) begin
                            w_q_nxt = r_q + c_q_one;
                        end else begin
                            w_done_nxt = 1'b1;
                            if (r_mode_l) begin
                                w_q_nxt = c_q_zero;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign Q    = r_q;
    assign TICK = r_tick;
    assign DONE = r_done;
    assign BUSY = (r_state == S_RUN) || (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_counter_sequence_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sequence_ctrl
// Brief    : Directed self-checking bench for counter_sequence_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_sequence_ctrl;

    logic       C;
    logic       CLR;
    logic       START;
    logic       STOP;
    logic       PAUSE;
    logic       MODE;
    logic [3:0] TC;
    logic [7:0] PRESCALE;
    logic [3:0] Q;
    logic       TICK;
    logic       BUSY;
    logic       DONE;

    int n_checks = 0;
    int n_fail   = 0;

    counter_sequence_ctrl #(.WIDTH(4), .PRE_W(8)) dut (
        .C        (C),
        .CLR      (CLR),
        .START    (START),
        .STOP     (STOP),
        .PAUSE    (PAUSE),
        .MODE     (MODE),
        .TC       (TC),
        .PRESCALE (PRESCALE),
        .Q        (Q),
        .TICK     (TICK),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge C);
        #1;
    endtask

    // Launch an interval: START is sampled on the next edge (edge 0).
    task automatic launch(input logic mode, input logic [3:0] tc, input logic [7:0] pre);
        MODE = mode; TC = tc; PRESCALE = pre; START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic halt();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [6:0] exp_v;
        n_checks++;
        if ({Q, BUSY, DONE, TICK} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_init: got %b expected %b", {Q, BUSY, DONE, TICK}, 7'd0);
        end
        launch(1'b0, 4'd9, 8'd0);
        for (int i = 1; i <= 5; i++) step();
        exp_v = {4'd5, 1'b1, 1'b0, 1'b1};
        n_checks++;
        if ({Q, BUSY, DONE, TICK} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_prerun: got %b expected %b", {Q, BUSY, DONE, TICK}, exp_v);
        end
        #2 CLR = 1'b1;
        #1;
        n_checks++;
        if ({Q, BUSY, DONE, TICK} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", {Q, BUSY, DONE, TICK}, 7'd0);
        end
        #2 CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({Q, BUSY, DONE, TICK} !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got %b expected %b", i, {Q, BUSY, DONE, TICK}, 7'd0);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [6:0] exp_v;
        logic [3:0] eq;
        launch(1'b0, 4'd3, 8'd1);
        n_checks++;
        if ({Q, BUSY} !== {4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL oneshot_start: got %b expected %b", {Q, BUSY}, {4'd0, 1'b1});
        end
        for (int i = 1; i <= 11; i++) begin
            step();
            eq = (i >= 6) ? 4'd3 : 4'(i / 2);
            exp_v = {eq, (i < 8), (i == 8), (i >= 2 && i <= 8 && (i % 2) == 0)};
            n_checks++;
            if ({Q, BUSY, DONE, TICK} !== exp_v) begin
                n_fail++;
                $display("FAIL oneshot e%0d: got %b expected %b", i, {Q, BUSY, DONE, TICK}, exp_v);
            end
        end
    endtask

    task automatic test_periodic();
        logic [6:0] exp_v;
        launch(1'b1, 4'd2, 8'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_v = {4'(i % 3), 1'b1, ((i % 3) == 0), 1'b1};
            n_checks++;
            if ({Q, BUSY, DONE, TICK} !== exp_v) begin
                n_fail++;
                $display("FAIL periodic e%0d: got %b expected %b", i, {Q, BUSY, DONE, TICK}, exp_v);
            end
        end
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({Q, BUSY, DONE, TICK} !== 7'd0) begin
                n_fail++;
                $display("FAIL periodic_stop c%0d: got %b expected %b", i, {Q, BUSY, DONE, TICK}, 7'd0);
            end
            step();
        end
    endtask

    task automatic test_pause();
        logic [5:0] exp_v;
        launch(1'b0, 4'd1, 8'd3);
        for (int i = 1; i <= 15; i++) begin
            PAUSE = (i >= 2 && i <= 6);
            step();
            exp_v = {((i >= 9) ? 4'd1 : 4'd0), (i < 13), (i == 13)};
            n_checks++;
            if ({Q, BUSY, DONE} !== exp_v) begin
                n_fail++;
                $display("FAIL pause e%0d: got %b expected %b", i, {Q, BUSY, DONE}, exp_v);
            end
        end
        PAUSE = 1'b0;
    endtask

    task automatic test_boundary();
        logic [5:0] exp_v;
        launch(1'b1, 4'd15, 8'd0);
        for (int i = 1; i <= 17; i++) begin
            step();
            exp_v = {4'(i % 16), 1'b1, ((i % 16) == 0)};
            n_checks++;
            if ({Q, BUSY, DONE} !== exp_v) begin
                n_fail++;
                $display("FAIL wrap15 e%0d: got %b expected %b", i, {Q, BUSY, DONE}, exp_v);
            end
        end
        halt();
        launch(1'b1, 4'd0, 8'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_v = {4'd0, 1'b1, 1'b1};
            n_checks++;
            if ({Q, BUSY, DONE} !== exp_v) begin
                n_fail++;
                $display("FAIL tc0 e%0d: got %b expected %b", i, {Q, BUSY, DONE}, exp_v);
            end
        end
        halt();
    endtask

    task automatic test_collisions();
        logic [5:0] exp_v;
        // STOP lands on the terminal edge (edge 4)
        launch(1'b0, 4'd1, 8'd1);
        for (int i = 1; i <= 3; i++) step();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_v = {4'd1, 1'b0, 1'b0};
            n_checks++;
            if ({Q, BUSY, DONE} !== exp_v) begin
                n_fail++;
                $display("FAIL stop_term c%0d: got %b expected %b", i, {Q, BUSY, DONE}, exp_v);
            end
            step();
        end
        // START lands on the terminal edge (edge 4); new interval ends at edge 8
        launch(1'b1, 4'd1, 8'd1);
        for (int i = 1; i <= 3; i++) step();
        START = 1'b1;
        step();
        START = 1'b0;
        exp_v = {4'd0, 1'b1, 1'b0};
        n_checks++;
        if ({Q, BUSY, DONE} !== exp_v) begin
            n_fail++;
            $display("FAIL start_term: got %b expected %b", {Q, BUSY, DONE}, exp_v);
        end
        for (int i = 5; i <= 8; i++) begin
            step();
            exp_v = {((i == 6 || i == 7) ? 4'd1 : 4'd0), 1'b1, (i == 8)};
            n_checks++;
            if ({Q, BUSY, DONE} !== exp_v) begin
                n_fail++;
                $display("FAIL restart e%0d: got %b expected %b", i, {Q, BUSY, DONE}, exp_v);
            end
        end
        halt();
        // TC changed while busy must not move the terminal count
        launch(1'b0, 4'd2, 8'd0);
        TC = 4'd9;
        PRESCALE = 8'd5;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_v = {((i >= 2) ? 4'd2 : 4'(i)), (i < 3), (i == 3)};
            n_checks++;
            if ({Q, BUSY, DONE} !== exp_v) begin
                n_fail++;
                $display("FAIL tc_change e%0d: got %b expected %b", i, {Q, BUSY, DONE}, exp_v);
            end
        end
    endtask

    initial begin
        CLR = 1'b1; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0;
        MODE = 1'b0; TC = 4'd0; PRESCALE = 8'd0;
        #22 CLR = 1'b0;
        step();
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_boundary();
        test_collisions();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
